// File: rtl/exec_mask_popcount.sv
// Sequential popcount / first-active-lane unit for a 64-lane execute mask.
// Walks the latched mask 16 lanes per cycle into a 7-bit ripple accumulator.
module exec_mask_popcount (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] exec_mask,
    input  logic        abort,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [6:0]  count,
    output logic [5:0]  first_lane,
    output logic        none_active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] mask_q, mask_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  acc_q, acc_d;
    logic [5:0]  first_q, first_d;
    logic        found_q, found_d;
    logic [6:0]  count_q, count_d;
    logic [5:0]  first_lane_q, first_lane_d;
    logic        none_active_q, none_active_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [15:0] chunk;
    logic [4:0]  partial;
    logic [3:0]  lsb_idx;
    logic [6:0]  add_b;
    logic [6:0]  acc_sum;
    logic [6:0]  carry;

    assign chunk = mask_q[{idx_q, 4'b0000} +: 16];

    always_comb begin
        partial = 5'd0;
        for (int i = 0; i < 16; i++) begin
            partial = partial + {4'd0, chunk[i]};
        end
    end

    // Scan high-to-low so the lowest set bit is the last one written.
    always_comb begin
        lsb_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (chunk[i]) begin
                lsb_idx = 4'(i);
            end
        end
    end

    // Accumulator adder: chain of full-adder cells, final carry never needed.
    assign add_b    = {2'b00, partial};
    assign carry[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_ripple
            assign acc_sum[gi] = acc_q[gi] ^ add_b[gi] ^ carry[gi];
            if (gi < 6) begin : g_carry
                assign carry[gi+1] = (acc_q[gi] & add_b[gi]) |
                                     (carry[gi] & (acc_q[gi] ^ add_b[gi]));
            end
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        first_d       = first_q;
        found_d       = found_q;
        count_d       = count_q;
        first_lane_d  = first_lane_q;
        none_active_d = none_active_q;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mask_d  = exec_mask;
                    acc_d   = 7'd0;
                    found_d = 1'b0;
                    first_d = 6'd0;
                    idx_d   = 2'd0;
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    if (!found_q && (chunk != 16'd0)) begin
                        found_d = 1'b1;
                        first_d = {idx_q, lsb_idx};
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d       = ST_DONE;
                        done_d        = 1'b1;
                        count_d       = acc_sum;
                        first_lane_d  = found_d ? first_d : 6'd0;
                        none_active_d = ~found_d;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_COUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mask_q        <= 64'd0;
            idx_q         <= 2'd0;
            acc_q         <= 7'd0;
            first_q       <= 6'd0;
            found_q       <= 1'b0;
            count_q       <= 7'd0;
            first_lane_q  <= 6'd0;
            none_active_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            first_q       <= first_d;
            found_q       <= found_d;
            count_q       <= count_d;
            first_lane_q  <= first_lane_d;
            none_active_q <= none_active_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign ready       = (state_q != ST_COUNT);
    assign busy        = busy_q;
    assign done        = done_q;
    assign count       = count_q;
    assign first_lane  = first_lane_q;
    assign none_active = none_active_q;

endmodule

// File: tb/tb_exec_mask_popcount.sv
// Scoreboard bench for exec_mask_popcount: driver pushes model results,
// a negedge monitor pops them on done and checks held results otherwise.
module tb_exec_mask_popcount;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] exec_mask;
    logic        abort;
    logic        ready;
    logic        busy;
    logic        done;
    logic [6:0]  count;
    logic [5:0]  first_lane;
    logic        none_active;

    exec_mask_popcount dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .exec_mask  (exec_mask),
        .abort      (abort),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .first_lane (first_lane),
        .none_active(none_active)
    );

    typedef struct {
        logic [6:0] cnt;
        logic [5:0] first;
        logic       none;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_start = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain bit counting and lowest-index search over the whole mask.
    function automatic exp_t model(input logic [63:0] m);
        exp_t e;
        e.cnt   = 7'($countones(m));
        e.first = 6'd0;
        e.none  = 1'b1;
        e.due   = 0;
        for (int i = 63; i >= 0; i--) begin
            if (m[i]) begin
                e.first = 6'(i);
                e.none  = 1'b0;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held.cnt   = 7'd0;
            held.first = 6'd0;
            held.none  = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_count", 64'(count), 64'(e.cnt));
                chk("done_first_lane", 64'(first_lane), 64'(e.first));
                chk("done_none_active", 64'(none_active), 64'(e.none));
                chk("done_latency_cycle", 64'(cyc), 64'(e.due));
                held = e;
            end
        end else begin
            chk("hold_count", 64'(count), 64'(held.cnt));
            chk("hold_first_lane", 64'(first_lane), 64'(held.first));
            chk("hold_none_active", 64'(none_active), 64'(held.none));
        end
    end

    // Issue one request when ready; push its expected result unless it will be cancelled.
    task automatic req(input logic [63:0] m, input bit push_exp);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
        start     = 1'b1;
        exec_mask = m;
        @(posedge clk);
        #1;
        e     = model(m);
        e.due = cyc + 4;
        if (push_exp) sb.push_back(e);
        last_start = cyc;
        start      = 1'b0;
        exec_mask  = {$urandom(), $urandom()};
        $display("req mask=%016h exp_count=%0d exp_first=%0d exp_none=%0d push=%0d",
                 m, e.cnt, e.first, e.none, push_exp);
    endtask

    task automatic wait_idle_empty();
        int w;
        w = 0;
        while ((sb.size() != 0 || !ready) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] rand_mask();
        logic [63:0] m;
        case ($urandom_range(0, 3))
            0: m = {$urandom(), $urandom()};
            1: m = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            2: m = 64'd1 << $urandom_range(0, 63);
            default: m = ($urandom_range(0, 1) == 0) ? 64'd0 : (64'h8000_0000_0000_0000 >> $urandom_range(0, 63));
        endcase
        return m;
    endfunction

    initial begin
        int s1;
        int s2;
        rst_n     = 1'b0;
        start     = 1'($urandom());
        abort     = 1'($urandom());
        exec_mask = {$urandom(), $urandom()};
        #2;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_first_lane", 64'(first_lane), 64'd0);
        chk("rst_none_active", 64'(none_active), 64'd0);
        start = 1'b0;
        abort = 1'b0;
        #10 rst_n = 1'b1;
        #1 chk("rst_ready", 64'(ready), 64'd1);

        req(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        req(64'h0, 1'b1);
        req(64'h8000_0000_0001_0000, 1'b1);
        req(64'h8000_0000_0000_0000, 1'b1);
        wait_idle_empty();

        // Start pulses while counting must be ignored; then restart in the DONE cycle.
        req(64'h0F, 1'b1);
        s1 = last_start;
        @(negedge clk);
        chk("busy_in_count", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b1; exec_mask = 64'hFF;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        req(64'h3, 1'b1);
        s2 = last_start;
        chk("restart_interval", 64'(s2 - s1), 64'd5);
        wait_idle_empty();

        // Abort mid-count: no done, result stays 2, back to IDLE.
        req(64'hFFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(count), 64'd2);
        repeat (6) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                int k;
                k = $urandom_range(1, 4);
                req(rand_mask(), 1'b0);
                repeat (k - 1) @(negedge clk);
                @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end else begin
                req(rand_mask(), 1'b1);
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle_empty();

        // Reset in the middle of a count.
        req(rand_mask() | 64'h1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_ready", 64'(ready), 64'd1);
        #9 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        req(64'hF0F0_0000_0000_0000, 1'b1);
        wait_idle_empty();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
